frame_burst_reader: RTL and testbench

- Avalon-MM read master that streams the frame buffer from SDRAM, one burst at a time, into the pixel FIFO write port.
- Sits directly upstream of the VGA timing/output stage, which drains the FIFO in the pixel domain.
- Runs entirely in the SDRAM/Avalon clock domain.
- Fetches HDISP*VDISP 32-bit pixels per frame, then wraps to the frame base address.

---
 rtl/frame_burst_reader.sv | 126 ++++++++++++
 tb/tb_frame_burst_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_burst_reader.sv
// Avalon-MM burst read master: streams a HDISP*VDISP frame of 32-bit pixels from SDRAM
// into the pixel FIFO write port, one burst outstanding at a time, wrapping at frame end.
module frame_burst_reader #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          BURSTSIZE = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  output logic [31:0]                  avm_address,
  output logic                         avm_read,
  output logic [$clog2(BURSTSIZE):0]   avm_burstcount,
  output logic [3:0]                   avm_byteenable,
  output logic                         avm_write,
  input  logic                         avm_waitrequest,
  input  logic [31:0]                  avm_readdata,
  input  logic                         avm_readdatavalid,
  output logic [31:0]                  fifo_wdata,
  output logic                         fifo_write,
  input  logic                         fifo_almost_full,
  output logic                         frame_done
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int WW    = $clog2(TOTAL + 1);
  localparam int BW    = $clog2(BURSTSIZE + 1);
  localparam int BCW   = $clog2(BURSTSIZE) + 1;

  localparam logic [31:0]   BURST_BYTES = 32'(4 * BURSTSIZE);
  localparam logic [WW-1:0] LAST_WORD   = WW'(TOTAL - 1);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BURSTSIZE - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t        state_reg, state_next;
  logic          read_reg, read_next;
  logic [31:0]   addr_reg, addr_next;
  logic [BW-1:0] beat_reg, beat_next;
  logic [WW-1:0] word_reg, word_next;
  logic          fifo_write_reg;
  logic [31:0]   fifo_wdata_reg;
  logic          frame_done_reg;
  logic          beat_valid;

  // Stray readdatavalid outside DATA (e.g. in flight across a reset) is dropped here.
  assign beat_valid = (state_reg == DATA) && avm_readdatavalid;

  always_comb begin
    state_next = state_reg;
    read_next  = read_reg;
    addr_next  = addr_reg;
    beat_next  = beat_reg;
    word_next  = word_reg;
    case (state_reg)
      IDLE: begin
        if (!enable) begin
          addr_next = BASE_ADDR;
          word_next = '0;
        end else if (!fifo_almost_full) begin
          read_next  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          read_next  = 1'b0;
          beat_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (avm_readdatavalid) begin
          beat_next = beat_reg + 1'b1;
          word_next = word_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            state_next = IDLE;
            // The last burst of a frame rewinds to the frame base.
            if (word_reg == LAST_WORD) begin
              addr_next = BASE_ADDR;
              word_next = '0;
            end else begin
              addr_next = addr_reg + BURST_BYTES;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      read_reg       <= 1'b0;
      addr_reg       <= BASE_ADDR;
      beat_reg       <= '0;
      word_reg       <= '0;
      fifo_write_reg <= 1'b0;
      fifo_wdata_reg <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      read_reg       <= read_next;
      addr_reg       <= addr_next;
      beat_reg       <= beat_next;
      word_reg       <= word_next;
      fifo_write_reg <= beat_valid;
      if (beat_valid) begin
        fifo_wdata_reg <= avm_readdata;
      end
      frame_done_reg <= beat_valid && (word_reg == LAST_WORD);
    end
  end

  assign avm_address    = addr_reg;
  assign avm_read       = read_reg;
  assign avm_burstcount = BCW'(BURSTSIZE);
  assign avm_byteenable = 4'hF;
  assign avm_write      = 1'b0;
  assign fifo_write     = fifo_write_reg;
  assign fifo_wdata     = fifo_wdata_reg;
  assign frame_done     = frame_done_reg;

endmodule

// File: tb/tb_frame_burst_reader.sv
// Directed/randomized bench for frame_burst_reader on a small 32x2 frame (4 bursts of 16 words).
module tb_frame_burst_reader;

  localparam int          HDISP     = 32;
  localparam int          VDISP     = 2;
  localparam int          BURSTSIZE = 16;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int          TOTAL     = HDISP * VDISP;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [4:0]  avm_burstcount;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] fifo_wdata;
  logic        fifo_write;
  logic        fifo_almost_full;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int frame_words = 0;  // reference model: words already fetched in the current frame

  frame_burst_reader #(
    .HDISP(HDISP), .VDISP(VDISP), .BURSTSIZE(BURSTSIZE), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_burstcount(avm_burstcount),
    .avm_byteenable(avm_byteenable),
    .avm_write(avm_write),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .fifo_wdata(fifo_wdata),
    .fifo_write(fifo_write),
    .fifo_almost_full(fifo_almost_full),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (avm_read !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("req_timeout", 32'(n < 100), 32'd1);
  endtask

  // Issue-side handshake: check the request, stall it wcyc cycles, then accept.
  task automatic accept(input int wcyc);
    logic [31:0] exp_addr;
    exp_addr = BASE + 32'(4 * frame_words);
    wait_req();
    check("req_addr", avm_address, exp_addr);
    check("burstcount", 32'(avm_burstcount), 32'(BURSTSIZE));
    check("byteenable", 32'(avm_byteenable), 32'hF);
    check("write_low", 32'(avm_write), 32'd0);
    for (int i = 0; i < wcyc; i++) begin
      avm_waitrequest = 1'b1;
      tick();
      check("stall_read", 32'(avm_read), 32'd1);
      check("stall_addr", avm_address, exp_addr);
      check("stall_bcnt", 32'(avm_burstcount), 32'(BURSTSIZE));
    end
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    check("read_dropped", 32'(avm_read), 32'd0);
  endtask

  // Deliver one data beat after `gap` idle cycles and check the registered FIFO write.
  task automatic beat(input int gap);
    logic [31:0] d;
    for (int i = 0; i < gap; i++) begin
      tick();
      check("gap_nowrite", 32'(fifo_write), 32'd0);
      check("gap_noread", 32'(avm_read), 32'd0);
    end
    d = {8'h00, 24'($urandom)};
    avm_readdata      = d;
    avm_readdatavalid = 1'b1;
    tick();
    avm_readdatavalid = 1'b0;
    check("fifo_write", 32'(fifo_write), 32'd1);
    check("fifo_wdata", fifo_wdata, d);
    check("frame_done", 32'(frame_done), 32'(frame_words == TOTAL - 1));
    frame_words = (frame_words + 1) % TOTAL;
  endtask

  task automatic do_burst(input int wcyc, input int gmin, input int gmax, input int drop_at);
    accept(wcyc);
    for (int b = 0; b < BURSTSIZE; b++) begin
      if (b == drop_at) enable = 1'b0;
      beat(int'($urandom_range(gmax, gmin)));
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    enable            = 1'b0;
    avm_waitrequest   = 1'b1;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    fifo_almost_full  = 1'b0;
    tick();
    tick();
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", avm_address, BASE);
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_fifo_wdata", fifo_wdata, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("const_bcnt", 32'(avm_burstcount), 32'(BURSTSIZE));
    check("const_write", 32'(avm_write), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("disabled_noread", 32'(avm_read), 32'd0);
    end

    // Back-to-back bursts, then a 5-cycle stall on the second request.
    enable = 1'b1;
    do_burst(0, 0, 0, -1);
    do_burst(5, 0, 0, -1);

    // almost_full holds off the next request for 20 cycles.
    fifo_almost_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("af_noread", 32'(avm_read), 32'd0);
    end
    fifo_almost_full = 1'b0;
    tick();
    check("af_release_read", 32'(avm_read), 32'd1);
    do_burst(1, 0, 2, -1);
    do_burst(0, 0, 2, -1);   // last burst of the frame: frame_done on word 63
    do_burst(2, 0, 1, -1);   // wrapped back to BASE

    // 3-cycle gaps with enable dropped mid-burst: burst completes, then stays idle.
    do_burst(0, 3, 3, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("disabled_idle", 32'(avm_read), 32'd0);
    end
    check("disabled_addr", avm_address, BASE);
    frame_words = 0;
    enable = 1'b1;
    do_burst(0, 0, 1, -1);

    // Reset asserted right after beat 7 of a burst.
    accept(1);
    for (int b = 0; b < 8; b++) beat(0);
    reset_n = 1'b0;
    #1;
    check("arst_read", 32'(avm_read), 32'd0);
    check("arst_fifo_write", 32'(fifo_write), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_addr", avm_address, BASE);
    tick();
    tick();
    reset_n = 1'b1;
    frame_words = 0;
    for (int i = 0; i < 3; i++) begin
      avm_readdata      = $urandom;
      avm_readdatavalid = 1'b1;
      tick();
      check("stray_nowrite", 32'(fifo_write), 32'd0);
    end
    avm_readdatavalid = 1'b0;
    tick();
    check("stray_nowrite_tail", 32'(fifo_write), 32'd0);
    do_burst(0, 0, 0, -1);

    // Randomized tail: stalls, gaps and almost_full back-pressure.
    for (int k = 0; k < 6; k++) begin
      int hold;
      hold = int'($urandom_range(3, 0));
      if (hold > 0) begin
        fifo_almost_full = 1'b1;
        for (int i = 0; i < hold; i++) begin
          tick();
          check("rand_af_noread", 32'(avm_read), 32'd0);
        end
        fifo_almost_full = 1'b0;
        tick();
        check("rand_af_read", 32'(avm_read), 32'd1);
      end
      do_burst(int'($urandom_range(3, 0)), 0, 2, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
